// File: rtl/ps2kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard command sequencer.
package ps2kbd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SC,
        S_RD_ST,
        S_CLR_RX,
        S_DISPATCH,
        S_TX_WR,
        S_TX_POLL,
        S_TX_ABORT,
        S_WAIT_RSP,
        S_ERR_CLR
    } ps2seq_state_t;

    // Register offsets from the keyboard core base address
    localparam logic [31:0] REG_DATA = 32'd0;
    localparam logic [31:0] REG_STAT = 32'd1;

    // Status byte bit positions
    localparam int unsigned ST_RX_BIT    = 7;
    localparam int unsigned ST_TC_BIT    = 6;
    localparam int unsigned ST_NKACK_BIT = 5;
    localparam int unsigned ST_PERR_BIT  = 0;

    // Keyboard protocol and status-clear bytes
    localparam logic [7:0] KBD_ACK     = 8'hFA;
    localparam logic [7:0] KBD_RESEND  = 8'hFE;
    localparam logic [7:0] STAT_CLR_RX = 8'h00;
    localparam logic [7:0] STAT_CLR_TX = 8'hFF;

    // Byte-lane select for a byte access at the given address
    function automatic logic [3:0] lane_sel(input logic [1:0] adr_lo);
        return 4'b0001 << adr_lo;
    endfunction

    // States that own a bus transaction
    function automatic logic is_bus_state(input ps2seq_state_t s);
        return (s == S_RD_SC)  || (s == S_RD_ST)   || (s == S_CLR_RX) ||
               (s == S_TX_WR)  || (s == S_TX_POLL) || (s == S_TX_ABORT) ||
               (s == S_ERR_CLR);
    endfunction

endpackage

// File: rtl/ps2_scan_fifo.sv
// Synchronous first-word-fall-through FIFO for received scan codes.
module ps2_scan_fifo
    import ps2kbd_pkg::*;
#(
    parameter int unsigned pDepth = 16,
    parameter int unsigned pWidth = 8
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [pWidth-1:0] i_data,
    input  logic              i_pop,
    output logic [pWidth-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(pDepth);

    logic [pWidth-1:0] r_mem [pDepth];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    // A push while full is still taken when the head is leaving this cycle
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

    // Pointer update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed on the data array
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ps2kbd_cmd_seq.sv
// Bus-master sequencer for the PS/2 keyboard core: drains scan codes into a
// FIFO and runs host-to-keyboard commands with ACK/resend, timeouts, retries.
module ps2kbd_cmd_seq
    import ps2kbd_pkg::*;
#(
    parameter int unsigned pClkFreq    = 50000000,
    parameter logic [31:0] KBD_ADDR    = 32'hFDFF8000,
    parameter int unsigned pTxTimeout  = pClkFreq / 50,
    parameter int unsigned pRspTimeout = pClkFreq / 50,
    parameter int unsigned pRetries    = 3,
    parameter int unsigned pFifoDepth  = 16
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_byte_i,
    input  logic        cmd_has_arg_i,
    input  logic [7:0]  cmd_arg_i,
    output logic        cmd_done_o,
    output logic        cmd_err_o,
    output logic        sc_valid_o,
    input  logic        sc_ready_i,
    output logic [7:0]  sc_data_o,
    output logic [7:0]  perr_cnt_o,
    input  logic        kbd_irq_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    ps2seq_state_t r_state;
    ps2seq_state_t w_state_nxt;

    logic [23:0] r_timer;
    logic        r_gap;
    logic        r_cmd_active;
    logic        r_arg_pend;
    logic [7:0]  r_cur;
    logic [7:0]  r_arg;
    logic [7:0]  r_retry;
    logic [7:0]  r_sc;
    logic        r_st_perr;
    logic [7:0]  r_perr;
    logic        r_done;
    logic        r_err;

    logic        w_bus;
    logic        w_cyc;
    logic        w_ack;
    logic        w_we;
    logic [31:0] w_adr_off;
    logic [31:0] w_adr;
    logic [7:0]  w_wbyte;
    logic        w_ready;
    logic        w_accept;
    logic        w_push;
    logic        w_perr_par;
    logic        w_arg_fire;
    logic        w_retry_req;
    logic        w_done_set;
    logic        w_err_set;
    logic [7:0]  w_retry_inc;
    logic        w_retry_over;
    logic        w_tx_expired;
    logic        w_rsp_expired;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_push_drop;
    logic        w_perr_inc;
    logic        w_unused;

    assign w_unused = ^m_dat_i[31:8];

    // Bus strobes drop for one cycle after every ack so ops are always separated
    assign w_bus  = is_bus_state(r_state);
    assign w_cyc  = w_bus & ~r_gap;
    assign w_ack  = w_cyc & m_ack_i;
    assign w_adr  = KBD_ADDR + w_adr_off;

    assign m_cyc_o = w_cyc;
    assign m_stb_o = w_cyc;
    assign m_we_o  = w_cyc & w_we;
    assign m_adr_o = w_cyc ? w_adr : '0;
    assign m_sel_o = w_cyc ? lane_sel(w_adr[1:0]) : '0;
    assign m_dat_o = (w_cyc & w_we) ? {4{w_wbyte}} : '0;

    // Withheld while irq is pending so a visible ready always means acceptance
    assign w_ready     = (r_state == S_IDLE) && !r_cmd_active && !kbd_irq_i;
    assign cmd_ready_o = w_ready;
    assign cmd_done_o  = r_done;
    assign cmd_err_o   = r_err;
    assign perr_cnt_o  = r_perr;
    assign sc_valid_o  = ~w_fifo_empty;

    assign w_retry_inc   = r_retry + 8'd1;
    assign w_retry_over  = (32'(w_retry_inc) > pRetries);
    assign w_tx_expired  = (32'(r_timer) >= pTxTimeout);
    assign w_rsp_expired = (32'(r_timer) >= pRspTimeout);

    assign w_pop       = sc_ready_i & ~w_fifo_empty;
    assign w_push_drop = w_push & w_fifo_full & ~w_pop;
    assign w_perr_inc  = w_perr_par | w_push_drop;

    ps2_scan_fifo #(
        .pDepth (pFifoDepth),
        .pWidth (8)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_data  (r_sc),
        .i_pop   (w_pop),
        .o_data  (sc_data_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state, bus op decode and dispatch decisions
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_perr_par  = 1'b0;
        w_arg_fire  = 1'b0;
        w_retry_req = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        w_we        = 1'b0;
        w_adr_off   = REG_DATA;
        w_wbyte     = '0;

        unique case (r_state)
            S_IDLE: begin
                if (kbd_irq_i) begin
                    w_state_nxt = S_RD_SC;
                end else if (cmd_valid_i && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_TX_WR;
                end
            end
            S_RD_SC: begin
                if (w_ack) w_state_nxt = S_RD_ST;
            end
            S_RD_ST: begin
                w_adr_off = REG_STAT;
                if (w_ack) w_state_nxt = S_CLR_RX;
            end
            S_CLR_RX: begin
                w_we      = 1'b1;
                w_adr_off = REG_STAT;
                w_wbyte   = STAT_CLR_RX;
                if (w_ack) w_state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (r_st_perr) begin
                    w_perr_par = 1'b1;
                    if (r_cmd_active) w_retry_req = 1'b1;
                    else              w_state_nxt = S_IDLE;
                end else if (r_cmd_active && (r_sc == KBD_ACK)) begin
                    if (r_arg_pend) begin
                        w_arg_fire  = 1'b1;
                        w_state_nxt = S_TX_WR;
                    end else begin
                        w_done_set  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cmd_active && (r_sc == KBD_RESEND)) begin
                    w_retry_req = 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = r_cmd_active ? S_WAIT_RSP : S_IDLE;
                end
            end
            S_TX_WR: begin
                w_we    = 1'b1;
                w_wbyte = r_cur;
                if (w_ack) w_state_nxt = S_TX_POLL;
            end
            S_TX_POLL: begin
                w_adr_off = REG_STAT;
                // Timeout is only acted on at a completed read so no op is cut short
                if (w_ack) begin
                    if (m_dat_i[ST_TC_BIT]) w_state_nxt = S_WAIT_RSP;
                    else if (w_tx_expired)  w_state_nxt = S_TX_ABORT;
                end
            end
            S_TX_ABORT: begin
                w_we      = 1'b1;
                w_adr_off = REG_STAT;
                w_wbyte   = STAT_CLR_TX;
                if (w_ack) w_retry_req = 1'b1;
            end
            S_WAIT_RSP: begin
                if (kbd_irq_i)          w_state_nxt = S_RD_SC;
                else if (w_rsp_expired) w_retry_req = 1'b1;
            end
            S_ERR_CLR: begin
                w_we      = 1'b1;
                w_adr_off = REG_STAT;
                w_wbyte   = STAT_CLR_TX;
                if (w_ack) begin
                    w_done_set  = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_retry_req) begin
            w_state_nxt = w_retry_over ? S_ERR_CLR : S_TX_WR;
        end
    end

    // State register and state-entry timer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_ack;
            if (w_state_nxt != r_state) r_timer <= '0;
            else if (r_timer != '1)     r_timer <= r_timer + 24'd1;
        end
    end

    // Command context: current byte, pending argument, retry count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd_active <= 1'b0;
            r_arg_pend   <= 1'b0;
            r_cur        <= '0;
            r_arg        <= '0;
            r_retry      <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_active <= 1'b1;
                r_arg_pend   <= cmd_has_arg_i;
                r_cur        <= cmd_byte_i;
                r_arg        <= cmd_arg_i;
                r_retry      <= '0;
            end else if (w_arg_fire) begin
                r_arg_pend <= 1'b0;
                r_cur      <= r_arg;
                r_retry    <= '0;
            end else if (w_retry_req) begin
                r_retry <= w_retry_inc;
            end
            if (w_done_set) r_cmd_active <= 1'b0;
        end
    end

    // Captured receive byte and parity flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sc      <= '0;
            r_st_perr <= 1'b0;
        end else begin
            if (w_ack && (r_state == S_RD_SC)) r_sc      <= m_dat_i[7:0];
            if (w_ack && (r_state == S_RD_ST)) r_st_perr <= m_dat_i[ST_PERR_BIT];
        end
    end

    // Done/error pulse and saturating drop counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_perr <= '0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_done_set & w_err_set;
            if (w_perr_inc && (r_perr != 8'hFF)) r_perr <= r_perr + 8'd1;
        end
    end

endmodule
